// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO host-bus interface.
//   - FSM state encoding for gpio_bus_if
//   - default synchroniser depth and bus widths
//   - small decode helpers for the active-low, synchronised strobes
package gpio_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int ADDR_W          = 6;
    localparam int DATA_W          = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        RD_DRIVE  = 3'd3,
        WR_ACC    = 3'd4,
        WR_COMMIT = 3'd5
    } gpio_state_t;

    // Host write phase: chip enabled and write strobe low.
    function automatic logic is_write_req(input logic ce_n, input logic we_n);
        return (ce_n == 1'b0) && (we_n == 1'b0);
    endfunction

    // Host read phase: chip and output enable low, write strobe idle.
    function automatic logic is_read_req(input logic ce_n, input logic oe_n,
                                         input logic we_n);
        return (ce_n == 1'b0) && (oe_n == 1'b0) && (we_n == 1'b1);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// N-stage, W-bit flop synchroniser with a parameterised reset value.
// Ports:
//   clk   - destination clock
//   rst_n - synchronous active-low reset, loads RST_VAL into every stage
//   d     - asynchronous input bits
//   q     - synchronised output (last stage)
module gpio_sync #(
    parameter int           N       = 2,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [N];

    // Shift chain; every stage resets to RST_VAL so idle strobes stay inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[N-1];

endmodule

// File: rtl/gpio_bus_if.sv
// Asynchronous SRAM-style host bus to single-clock register-file bridge.
// All host pins are synchronised, then a small FSM turns host read/write
// phases into one-cycle reg_re / reg_we strobes and drives read data back.
// Ports:
//   clk, RESETn         - core clock, synchronous active-low reset
//   addr_i, ceb_i,      - asynchronous host address and active-low
//   oeb_i, web_i, d_i     chip/output/write enables, host write data
//   d_o, d_oe           - read data toward the pads and its output enable
//   reg_addr, reg_wdata - register-file address and write data
//   reg_we, reg_re      - one-cycle write / read strobes
//   reg_rdata           - register-file read data, valid 1 clk after reg_re
module gpio_bus_if
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              ceb_i,
    input  logic              oeb_i,
    input  logic              web_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] d_o,
    output logic              d_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata
);

    logic              ce_s;
    logic              oe_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] d_s;

    gpio_state_t       state_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] d_o_r;
    logic              d_oe_r;
    logic [ADDR_W-1:0] reg_addr_r;
    logic [DATA_W-1:0] reg_wdata_r;
    logic              reg_we_r;
    logic              reg_re_r;

    // Strobes reset to the inactive (high) level so reset never fakes an access.
    gpio_sync #(
        .N       (SYNC_STAGES),
        .W       (3),
        .RST_VAL (3'b111)
    ) u_sync_strobe (
        .clk   (clk),
        .rst_n (RESETn),
        .d     ({ceb_i, oeb_i, web_i}),
        .q     ({ce_s, oe_s, we_s})
    );

    gpio_sync #(
        .N       (SYNC_STAGES),
        .W       (ADDR_W + DATA_W),
        .RST_VAL ({(ADDR_W + DATA_W){1'b0}})
    ) u_sync_bus (
        .clk   (clk),
        .rst_n (RESETn),
        .d     ({addr_i, d_i}),
        .q     ({addr_s, d_s})
    );

    // Bus FSM with registered outputs. Strobes are set on the transition into
    // RD_REQ / WR_COMMIT so they are high exactly while in those states.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_r     <= IDLE;
            rd_addr_r   <= {ADDR_W{1'b0}};
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            d_o_r       <= {DATA_W{1'b0}};
            d_oe_r      <= 1'b0;
            reg_addr_r  <= {ADDR_W{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
        end else begin
            reg_we_r <= 1'b0;
            reg_re_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    d_oe_r <= 1'b0;
                    // Write wins when OE and WE are both low.
                    if (is_write_req(ce_s, we_s)) begin
                        state_r   <= WR_ACC;
                        wr_addr_r <= addr_s;
                        wr_data_r <= d_s;
                    end else if (is_read_req(ce_s, oe_s, we_s)) begin
                        state_r    <= RD_REQ;
                        reg_re_r   <= 1'b1;
                        reg_addr_r <= addr_s;
                        rd_addr_r  <= addr_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Host gave up before data arrived: do not glitch the pads.
                    if (ce_s || oe_s) begin
                        state_r <= IDLE;
                        d_oe_r  <= 1'b0;
                    end else begin
                        state_r <= RD_DRIVE;
                        d_o_r   <= reg_rdata;
                        d_oe_r  <= 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (ce_s || oe_s) begin
                        state_r <= IDLE;
                        d_oe_r  <= 1'b0;
                    end else if (!we_s) begin
                        state_r   <= WR_ACC;
                        d_oe_r    <= 1'b0;
                        wr_addr_r <= addr_s;
                        wr_data_r <= d_s;
                    end else if (addr_s != rd_addr_r) begin
                        // Re-read at the new address; pads keep driving old data.
                        state_r    <= RD_REQ;
                        reg_re_r   <= 1'b1;
                        reg_addr_r <= addr_s;
                        rd_addr_r  <= addr_s;
                    end else begin
                        state_r <= RD_DRIVE;
                    end
                end
                WR_ACC: begin
                    d_oe_r <= 1'b0;
                    // Only samples taken while the strobe is still low are kept,
                    // so bus changes coincident with the rising strobe are ignored.
                    if (ce_s || we_s) begin
                        state_r     <= WR_COMMIT;
                        reg_we_r    <= 1'b1;
                        reg_addr_r  <= wr_addr_r;
                        reg_wdata_r <= wr_data_r;
                    end else begin
                        state_r   <= WR_ACC;
                        wr_addr_r <= addr_s;
                        wr_data_r <= d_s;
                    end
                end
                WR_COMMIT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    d_oe_r  <= 1'b0;
                end
            endcase
        end
    end

    assign d_o       = d_o_r;
    assign d_oe      = d_oe_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign reg_re    = reg_re_r;

endmodule

// File: tb/tb_gpio_bus_if.sv
// Directed, table-driven bench for gpio_bus_if with a register-file model.
module tb_gpio_bus_if;
    import gpio_pkg::*;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       RESETn;
    logic [5:0] addr_i;
    logic       ceb_i, oeb_i, web_i;
    logic [7:0] d_i;
    logic [7:0] d_o;
    logic       d_oe;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata;

    always #5 clk = ~clk;

    gpio_bus_if #(.SYNC_STAGES(SS)) dut (
        .clk(clk), .RESETn(RESETn), .addr_i(addr_i), .ceb_i(ceb_i),
        .oeb_i(oeb_i), .web_i(web_i), .d_i(d_i), .d_o(d_o), .d_oe(d_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Power-up register contents of the modelled register file.
    function automatic logic [7:0] init_val(input logic [5:0] a);
        logic [7:0] v;
        v = ({2'b00, a} * 8'd7) ^ 8'h5A;
        if (a == 6'h12) v = 8'h3C;
        if (a == 6'h13) v = 8'hC3;
        return v;
    endfunction

    // Register-file model: write on reg_we, read data one clk after reg_re.
    logic       model_clr = 1'b1;
    logic [7:0] mem      [64];
    logic       wr_valid [64];
    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 64; i++) wr_valid[i] <= 1'b0;
        end else begin
            if (reg_we) begin
                mem[reg_addr]      <= reg_wdata;
                wr_valid[reg_addr] <= 1'b1;
            end
            if (reg_re) reg_rdata <= wr_valid[reg_addr] ? mem[reg_addr] : init_val(reg_addr);
        end
    end

    // Strobe / pad monitor sampled on the falling edge.
    int         we_cnt = 0, re_cnt = 0, both_cnt = 0, doe_cnt = 0;
    logic [5:0] last_we_addr = 6'h00, last_re_addr = 6'h00;
    logic [7:0] last_we_data = 8'h00, last_rd_data = 8'h00;
    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= reg_addr;
            last_we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt       <= re_cnt + 1;
            last_re_addr <= reg_addr;
        end
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        if (d_oe) begin
            doe_cnt      <= doe_cnt + 1;
            last_rd_data <= d_o;
        end
    end

    logic [7:0] shadow  [64];
    logic       wr_flag [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ceb_i = 1'b1; oeb_i = 1'b1; web_i = 1'b1;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d, input int width);
        int we0, re0, doe0, lat;
        we0 = we_cnt; re0 = re_cnt; doe0 = doe_cnt; lat = 0;
        addr_i = a; d_i = d; ceb_i = 1'b0; web_i = 1'b0;
        repeat (width) step();
        bus_idle();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (we_cnt != we0 && lat == 0) lat = k;
        end
        check_range("wr_latency", lat, SS + 1, SS + 2);
        check("wr_we_count", we_cnt - we0, 1);
        check("wr_addr", last_we_addr, a);
        check("wr_data", last_we_data, d);
        check("wr_no_re", re_cnt - re0, 0);
        check("wr_no_doe", doe_cnt - doe0, 0);
        shadow[a] = d;
        wr_flag[a] = 1'b1;
    endtask

    task automatic host_read(input logic [5:0] a, input logic [7:0] exp, input int hold);
        int re0, lat;
        re0 = re_cnt; lat = 0;
        addr_i = a; ceb_i = 1'b0; oeb_i = 1'b0; web_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (d_oe === 1'b1) begin lat = k; break; end
        end
        check("rd_latency", lat, SS + 3);
        check("rd_data", d_o, exp);
        repeat (hold) step();
        check("rd_re_count", re_cnt - re0, 1);
        check("rd_addr", last_re_addr, a);
        bus_idle();
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (d_oe === 1'b0) begin lat = k; break; end
        end
        check_range("rd_release", lat, 1, SS + 1);
        repeat (3) step();
    endtask

    typedef struct {
        bit         is_wr;
        logic [5:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, re0, doe0, drops, upd, nw, nr;
        logic [5:0] a;
        logic [7:0] d;

        for (int i = 0; i < 64; i++) begin
            shadow[i]  = init_val(i[5:0]);
            wr_flag[i] = 1'b0;
        end
        tbl[0] = '{1'b1, 6'h05, 8'hA5};
        tbl[1] = '{1'b0, 6'h12, 8'h3C};
        tbl[2] = '{1'b0, 6'h05, 8'hA5};
        tbl[3] = '{1'b1, 6'h3F, 8'hFF};
        tbl[4] = '{1'b0, 6'h3F, 8'hFF};
        tbl[5] = '{1'b1, 6'h2A, 8'h5A};
        tbl[6] = '{1'b0, 6'h00, 8'h5A};
        tbl[7] = '{1'b0, 6'h2A, 8'h5A};

        // Reset state
        RESETn = 1'b0; addr_i = 6'h00; d_i = 8'h00; bus_idle();
        repeat (3) step();
        check("rst_d_o", d_o, 8'h00);
        check("rst_d_oe", d_oe, 1'b0);
        check("rst_reg_addr", reg_addr, 6'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_reg_re", reg_re, 1'b0);
        RESETn = 1'b1; model_clr = 1'b0;
        repeat (SS + 2) step();

        // Directed table
        for (int v = 0; v < 8; v++) begin
            if (tbl[v].is_wr) host_write(tbl[v].addr, tbl[v].data, 6);
            else              host_read(tbl[v].addr, tbl[v].data, 2);
        end

        // Address change during a held read
        re0 = re_cnt; drops = 0; upd = 0;
        addr_i = 6'h12; ceb_i = 1'b0; oeb_i = 1'b0; web_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (d_oe === 1'b1) break;
        end
        check("chg_first_data", d_o, 8'h3C);
        addr_i = 6'h13;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (d_oe !== 1'b1) drops++;
            if (d_o === 8'hC3 && upd == 0) upd = k;
        end
        check("chg_doe_drops", drops, 0);
        check_range("chg_update_time", upd, 1, 12);
        check("chg_new_data", d_o, 8'hC3);
        check("chg_re_count", re_cnt - re0, 2);
        check("chg_re_addr", last_re_addr, 6'h13);
        bus_idle();
        repeat (8) step();
        check("chg_doe_off", d_oe, 1'b0);

        // OE and WE low together: write only
        we0 = we_cnt; re0 = re_cnt; doe0 = doe_cnt;
        addr_i = 6'h01; d_i = 8'h7E; ceb_i = 1'b0; oeb_i = 1'b0; web_i = 1'b0;
        repeat (4) step();
        bus_idle();
        repeat (12) step();
        check("sim_no_re", re_cnt - re0, 0);
        check("sim_no_doe", doe_cnt - doe0, 0);
        check("sim_we_count", we_cnt - we0, 1);
        check("sim_we_addr", last_we_addr, 6'h01);
        check("sim_we_data", last_we_data, 8'h7E);
        shadow[1] = 8'h7E; wr_flag[1] = 1'b1;

        // Reset in the middle of a write pulse
        we0 = we_cnt;
        addr_i = 6'h20; d_i = 8'h99; ceb_i = 1'b0; web_i = 1'b0;
        repeat (4) step();
        RESETn = 1'b0;
        step();
        check("rstmid_outputs", {d_o, d_oe, reg_addr, reg_wdata, reg_we, reg_re}, 24'h0);
        RESETn = 1'b1; bus_idle();
        repeat (12) step();
        check("rstmid_no_we", we_cnt - we0, 0);
        host_write(6'h20, 8'h11, SS + 1);
        host_read(6'h20, 8'h11, 1);

        // Back-to-back random accesses at minimum strobe width
        we0 = we_cnt; re0 = re_cnt; nw = 0; nr = 0;
        for (int t = 0; t < 100; t++) begin
            a = 6'($urandom_range(0, 63));
            d = 8'($urandom_range(0, 255));
            addr_i = a;
            if ($urandom_range(0, 1) == 1) begin
                d_i = d; ceb_i = 1'b0; web_i = 1'b0;
                repeat (SS + 1) step();
                bus_idle();
                repeat (SS + 1) step();
                shadow[a] = d; wr_flag[a] = 1'b1; nw++;
            end else begin
                doe0 = doe_cnt;
                ceb_i = 1'b0; oeb_i = 1'b0;
                repeat (SS + 1) step();
                bus_idle();
                repeat (SS + 1) step();
                check("stress_rd_seen", (doe_cnt != doe0) ? 1 : 0, 1);
                check("stress_rd_data", last_rd_data, shadow[a]);
                nr++;
            end
        end
        repeat (10) step();
        check("stress_we_count", we_cnt - we0, nw);
        check("stress_re_count", re_cnt - re0, nr);

        // Read back every written address
        for (int i = 0; i < 64; i++) begin
            if (wr_flag[i]) host_read(i[5:0], shadow[i], 0);
        end

        check("we_re_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
